icache_refill_unit: RTL



---
 rtl/icache_pkg.sv | 24 ++
 rtl/refill_line_buffer.sv | 63 ++++++
 rtl/icache_refill_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared constants and state encoding for the instruction-cache refill path.
//   LINE_SIZE    : cache line width in bits
//   BEAT_WIDTH   : memory response beat width in bits
//   OFFSET_WIDTH : log2 of the line size in bytes (cleared on memory requests)
//   BEATS        : number of response beats that make up one line
//   state_e      : refill FSM states
// -----------------------------------------------------------------------------
package icache_pkg;

    localparam int LINE_SIZE    = 512;
    localparam int BEAT_WIDTH   = 64;
    localparam int OFFSET_WIDTH = 6;
    localparam int BEATS        = LINE_SIZE / BEAT_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        RESP   = 2'd2,
        REFILL = 2'd3
    } state_e;

endpackage : icache_pkg

// File: rtl/refill_line_buffer.sv
// -----------------------------------------------------------------------------
// refill_line_buffer
// Beat counter plus indexed line assembly: each accepted beat is written
// into its slot of the line (beat k lands in bits [k*BEAT_WIDTH +: BEAT_WIDTH]).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset (counter only)
//   clear_i       : restart assembly at beat 0
//   beat_valid_i  : a beat is accepted this cycle
//   beat_data_i   : beat payload
//   last_o        : the next accepted beat completes the line
//   line_o        : assembled line
// -----------------------------------------------------------------------------
module refill_line_buffer
    import icache_pkg::*;
#(
    parameter int LINE_W = icache_pkg::LINE_SIZE,
    parameter int BEAT_W = icache_pkg::BEAT_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              beat_valid_i,
    input  logic [BEAT_W-1:0] beat_data_i,
    output logic              last_o,
    output logic [LINE_W-1:0] line_o
);

    localparam int NUM_BEATS = LINE_W / BEAT_W;
    localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;

    assign last_o = (cnt_q == CNT_W'(NUM_BEATS - 1));
    assign line_o = line_q;

    always_comb begin
        cnt_d  = cnt_q;
        line_d = line_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (beat_valid_i) begin
            line_d[int'(cnt_q) * BEAT_W +: BEAT_W] = beat_data_i;
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // NOTE: the line storage is pure datapath and is fully rewritten before it
    // is ever presented, so it has no reset; keeping it out of the reset tree
    // lets it map onto plain (or memory-style) flops.
    always_ff @(posedge clk) begin
        line_q <= line_d;
    end

endmodule : refill_line_buffer

// File: rtl/icache_refill_unit.sv
// -----------------------------------------------------------------------------
// icache_refill_unit
// Single-outstanding-miss refill engine between the icache and the memory bus.
// Accepts a line miss, issues one line-aligned burst read, assembles the
// response beats into a full line and hands it back to the icache.
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   icache_miss_valid_i/_ready_o   : miss handshake
//   icache_miss_addr_i             : miss address (any byte within the line)
//   refill_icache_valid_o/_ready_i : refill handshake
//   refill_icache_data_o           : assembled line
//   mem_req_valid_o/_ready_i       : burst read request handshake
//   mem_req_addr_o                 : line-aligned request address
//   mem_resp_valid_i/_ready_o      : response beat handshake
//   mem_resp_data_i                : response beat data
// -----------------------------------------------------------------------------
module icache_refill_unit
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH   = 64,
    parameter int LINE_W       = icache_pkg::LINE_SIZE,
    parameter int BEAT_W       = icache_pkg::BEAT_WIDTH,
    parameter int OFFSET_W     = icache_pkg::OFFSET_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  icache_miss_valid_i,
    output logic                  icache_miss_ready_o,
    input  logic [ADDR_WIDTH-1:0] icache_miss_addr_i,
    output logic                  refill_icache_valid_o,
    input  logic                  refill_icache_ready_i,
    output logic [LINE_W-1:0]     refill_icache_data_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                  mem_resp_valid_i,
    output logic                  mem_resp_ready_o,
    input  logic [BEAT_W-1:0]     mem_resp_data_i
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  buf_clear;
    logic                  beat_accept;
    logic                  buf_last;

    // Beats arriving outside RESP are protocol errors and are dropped here.
    assign beat_accept    = mem_resp_ready_o & mem_resp_valid_i;
    assign mem_req_addr_o = addr_q;

    refill_line_buffer #(
        .LINE_W (LINE_W),
        .BEAT_W (BEAT_W)
    ) u_line_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear_i      (buf_clear),
        .beat_valid_i (beat_accept),
        .beat_data_i  (mem_resp_data_i),
        .last_o       (buf_last),
        .line_o       (refill_icache_data_o)
    );

    // Every handshake signal is decoded from a single state, so at most one
    // handshake can complete per cycle and all outputs come straight off
    // the state register.
    always_comb begin
        state_d               = state_q;
        addr_d                = addr_q;
        buf_clear             = 1'b0;
        icache_miss_ready_o   = 1'b0;
        mem_req_valid_o       = 1'b0;
        mem_resp_ready_o      = 1'b0;
        refill_icache_valid_o = 1'b0;

        unique case (state_q)
            IDLE: begin
                icache_miss_ready_o = 1'b1;
                if (icache_miss_valid_i) begin
                    addr_d  = {icache_miss_addr_i[ADDR_WIDTH-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    state_d = REQ;
                end
            end
            REQ: begin
                mem_req_valid_o = 1'b1;
                if (mem_req_ready_i) begin
                    buf_clear = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                mem_resp_ready_o = 1'b1;
                if (mem_resp_valid_i && buf_last) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                refill_icache_valid_o = 1'b1;
                if (refill_icache_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Captured address is only meaningful once a miss is accepted.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
    end

endmodule : icache_refill_unit
